wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits, >=32, multiple of 8.
REQ-002 SHALL have parameter REG_AW, default 5: register-file address width.
REQ-003 SHALL have parameter CNT_W, default 64: retired-instruction counter width.
REQ-004 SHALL use one clock, clk, with reset rst asynchronous and active-high.
REQ-005 Ports SHALL be:
  - clk  input  1  clock
  - rst  input  1  asynchronous active-high reset
  - in_valid  input  1  MEM stage presents an instruction
  - in_ready  output  1  stage can accept this cycle
  - in_rd_sel  input  3  result source select
  - in_rd_we  input  1  instruction writes rd
  - in_rd_addr  input  REG_AW  destination register
  - in_alu  input  XLEN  ALU result
  - in_mem  input  XLEN  raw load data word
  - in_imm  input  XLEN  immediate
  - in_pc  input  XLEN  instruction PC
  - in_ld_size  input  2  load size: 00 byte, 01 half, 10/11 word
  - in_ld_unsigned  input  1  zero-extend load
  - in_addr_lo  input  2  load address bits [1:0]
  - stall  input  1  hazard unit holds WB
  - flush  input  1  discard the instruction presented this cycle
  - rf_we  output  1  register-file write strobe
  - rf_waddr  output  REG_AW  write address
  - rf_wdata  output  XLEN  write data
  - instret  output  CNT_W  retired-instruction count

Function
REQ-006 in_ready SHALL equal !stall combinationally.
REQ-007 An instruction SHALL be accepted on a rising clk edge where in_valid && in_ready && !flush.
REQ-008 Latency SHALL be one cycle: rf_we/rf_waddr/rf_wdata are registered and appear the cycle after acceptance.
REQ-009 rf_we SHALL be a single-cycle pulse; it SHALL be 0 in every cycle not following an acceptance.
REQ-010 rf_waddr and rf_wdata SHALL hold their last values when no acceptance occurs.
REQ-011 rd_sel decode: 000 in_alu; 001 load data (REQ-015); 010 in_imm; 011 in_pc+4; 100 in_pc+in_imm; all sums modulo 2^XLEN.
REQ-012 rd_sel 101/110/111 SHALL be accepted with rf_we forced 0 and rf_wdata set to 0.
REQ-013 rf_we SHALL be in_rd_we && (in_rd_addr != 0) && legal rd_sel; writes to x0 SHALL be suppressed.
REQ-014 flush SHALL take priority over in_valid; a flushed instruction produces no write and no count.
REQ-015 Load data SHALL be formed per Configuration.
REQ-016 instret SHALL increment by 1 on each acceptance, including those with rf_we 0, and wrap from 2^CNT_W-1 to 0.
REQ-017 stall and flush asserted together SHALL yield no acceptance; the next-cycle output is rf_we 0.

Reset
REQ-018 While rst is high: rf_we 0, rf_waddr 0, rf_wdata 0, instret 0, immediately and independent of clk.
REQ-019 Reset mid-operation SHALL drop any pending registered write; the first acceptance after rst deassertion SHALL behave as REQ-007/008.

Configuration
REQ-020 Macro WB_LOAD_ALIGN_EN defined: byte load selects in_mem byte in_addr_lo; half load selects halfword in_addr_lo[1]; result sign-extended to XLEN unless in_ld_unsigned, then zero-extended; word load passes in_mem[31:0], extended likewise when XLEN>32.
REQ-021 Macro WB_LOAD_ALIGN_EN undefined: load data SHALL be in_mem unchanged; in_ld_size, in_ld_unsigned and in_addr_lo SHALL be ignored.

Verification
REQ-022 rd_sel 011, in_pc 0x0000_1000, rd 5, we 1 -> next cycle rf_we 1, rf_waddr 5, rf_wdata 0x0000_1004, instret 1.
REQ-023 WB_LOAD_ALIGN_EN set, in_mem 0x1234_80FF, byte, addr_lo 01, signed -> rf_wdata 0xFFFF_FF80; same unsigned -> 0x0000_0080; half addr_lo 10 signed -> 0x0000_1234.
REQ-024 rd_sel 000, rd 0, we 1, in_alu 0xDEAD_BEEF -> rf_we 0, instret increments; rd_sel 110 rd 3 -> rf_we 0, rf_wdata 0.
REQ-025 stall high 3 cycles with in_valid high -> in_ready 0, rf_we 0 throughout, instret unchanged; stall low -> accept, write next cycle.
REQ-026 flush with in_valid, then rst pulse mid-stream after an acceptance -> no write from the flushed op; outputs 0 asynchronously on rst; instret preset to 2^CNT_W-1 (CNT_W 4: 15) then one acceptance -> 0.

Source files
------------

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage.
//
// Picks the result for an instruction leaving MEM and turns it into a
// register-file write. The write is registered, so it appears one cycle after
// the instruction is accepted. The stage also counts retired instructions.
//
// Optional feature, selected by the macro WB_LOAD_ALIGN_EN:
//   defined   - load data is the addressed byte or halfword, or the low word,
//               taken from in_mem and sign- or zero-extended to XLEN.
//   undefined - load data is in_mem unchanged; in_ld_size, in_ld_unsigned and
//               in_addr_lo are ignored.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   in_valid        MEM stage presents an instruction
//   in_ready        stage can accept this cycle (= !stall)
//   in_rd_sel       result source: 0 alu, 1 load, 2 imm, 3 pc+4, 4 pc+imm,
//                   5..7 accepted, but they never write
//   in_rd_we        instruction writes rd
//   in_rd_addr      destination register (x0 is never written)
//   in_alu, in_mem, in_imm, in_pc   operand sources
//   in_ld_size      00 byte, 01 half, 1x word
//   in_ld_unsigned  zero-extend load data
//   in_addr_lo      load address bits [1:0]
//   stall           hold: nothing is accepted
//   flush           discard the instruction presented this cycle
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   instret         retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_rd_sel,
    input  logic              in_rd_we,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_mem,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_unsigned,
    input  logic [1:0]        in_addr_lo,
    input  logic              stall,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [2:0] SEL_ALU    = 3'd0;
    localparam logic [2:0] SEL_LOAD   = 3'd1;
    localparam logic [2:0] SEL_IMM    = 3'd2;
    localparam logic [2:0] SEL_PC4    = 3'd3;
    localparam logic [2:0] SEL_PC_IMM = 3'd4;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              accept;
    logic              sel_legal;
    logic [XLEN-1:0]   ld_data;
    logic [XLEN-1:0]   result_next;
    logic              rf_we_next;

    logic              rf_we_reg;
    logic [REG_AW-1:0] rf_waddr_reg;
    logic [XLEN-1:0]   rf_wdata_reg;
    logic [CNT_W-1:0]  instret_reg;

    // flush wins over in_valid; stall blocks acceptance even with flush.
    assign in_ready = !stall;
    assign accept   = in_valid && !stall && !flush;

`ifdef WB_LOAD_ALIGN_EN
    localparam logic [XLEN-1:0] ONE    = XLEN'(1);
    // Bits above the loaded field, set when sign-extending. For a word load
    // with XLEN == 32 the shift overflows to 0, so the mask becomes 0.
    localparam logic [XLEN-1:0] MASK_B = ~((ONE << 8)  - ONE);
    localparam logic [XLEN-1:0] MASK_H = ~((ONE << 16) - ONE);
    localparam logic [XLEN-1:0] MASK_W = ~((ONE << 32) - ONE);

    logic [7:0]      mem_byte [4];
    logic [15:0]     mem_half [2];
    logic [31:0]     ld_raw;
    logic            ld_sign;
    logic [XLEN-1:0] ld_mask;
    logic            unused_mem_hi;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign mem_byte[gi] = in_mem[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign mem_half[gi] = in_mem[16*gi +: 16];
        end
    endgenerate

    // Bits above 31 are never loaded.
    assign unused_mem_hi = ^in_mem;

    always_comb begin
        ld_raw  = in_mem[31:0];
        ld_sign = in_mem[31];
        ld_mask = MASK_W;
        case (in_ld_size)
            2'b00: begin
                ld_raw  = {24'd0, mem_byte[in_addr_lo]};
                ld_sign = mem_byte[in_addr_lo][7];
                ld_mask = MASK_B;
            end
            2'b01: begin
                ld_raw  = {16'd0, mem_half[in_addr_lo[1]]};
                ld_sign = mem_half[in_addr_lo[1]][15];
                ld_mask = MASK_H;
            end
            default: begin
                ld_raw  = in_mem[31:0];
                ld_sign = in_mem[31];
                ld_mask = MASK_W;
            end
        endcase
        ld_data = XLEN'(ld_raw) | ((ld_sign && !in_ld_unsigned) ? ld_mask : '0);
    end
`else
    logic unused_ld_ctrl;

    assign unused_ld_ctrl = ^{in_ld_size, in_ld_unsigned, in_addr_lo};
    assign ld_data        = in_mem;
`endif

    // Result mux; codes 5..7 give 0 and never write.
    always_comb begin
        result_next = '0;
        sel_legal   = 1'b1;
        case (in_rd_sel)
            SEL_ALU:    result_next = in_alu;
            SEL_LOAD:   result_next = ld_data;
            SEL_IMM:    result_next = in_imm;
            SEL_PC4:    result_next = in_pc + PC_STEP;
            SEL_PC_IMM: result_next = in_pc + in_imm;
            default: begin
                result_next = '0;
                sel_legal   = 1'b0;
            end
        endcase
    end

    assign rf_we_next = accept && in_rd_we && (in_rd_addr != '0) && sel_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            instret_reg  <= '0;
        end else begin
            // rf_we is a one-cycle pulse; address/data hold between acceptances.
            rf_we_reg <= rf_we_next;
            if (accept) begin
                rf_waddr_reg <= in_rd_addr;
                rf_wdata_reg <= result_next;
                instret_reg  <= instret_reg + CNT_ONE;
            end
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign instret  = instret_reg;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_rd_sel;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_alu, in_mem, in_imm, in_pc;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_addr_lo;
    logic        stall, flush;

    logic        in_ready, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    logic        s_in_ready, s_rf_we;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic [3:0]  s_instret;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_cnt = 64'd0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_sel(in_rd_sel), .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
        .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm), .in_pc(in_pc),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_lo(in_addr_lo), .stall(stall), .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .instret(instret)
    );

    // Narrow counter instance for the wrap check.
    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_rd_sel(in_rd_sel), .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
        .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm), .in_pc(in_pc),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_addr_lo(in_addr_lo), .stall(stall), .flush(flush),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata), .instret(s_instret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rd_sel = 3'd0; in_rd_we = 1'b0; in_rd_addr = 5'd0;
        in_alu = 32'd0; in_mem = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
        in_ld_size = 2'b10; in_ld_unsigned = 1'b0; in_addr_lo = 2'b00;
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] mem);
        in_valid = 1'b1; in_rd_sel = sel; in_rd_we = 1'b1; in_rd_addr = rd;
        in_alu = alu; in_imm = imm; in_pc = pc; in_mem = mem;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; idle();
        step(); step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b want=0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
        total++; if (instret !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", instret); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
        rst = 1'b0;
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL post_reset_we got=%0b want=0", rf_we); end
        $display("test_reset done");
    endtask

    task automatic test_pc4();
        issue(3'd3, 5'd5, 32'd0, 32'd0, 32'h0000_1000, 32'd0);
        step(); exp_cnt++;
        idle();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL pc4_we got=%0b want=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL pc4_waddr got=%0d want=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h0000_1004) begin bad++; $display("FAIL pc4_wdata got=%h want=00001004", rf_wdata); end
        total++; if (instret !== 64'd1) begin bad++; $display("FAIL pc4_instret got=%0d want=1", instret); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL pc4_pulse got=%0b want=0", rf_we); end
        total++; if (rf_wdata !== 32'h0000_1004) begin bad++; $display("FAIL pc4_hold got=%h want=00001004", rf_wdata); end
        $display("test_pc4 done");
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 5'd7, 32'hA5A5_0001, 32'd0, 32'd0, 32'd0);
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA5A5_0001)
            begin bad++; $display("FAIL b2b_alu got=%0b/%0d/%h want=1/7/a5a50001", rf_we, rf_waddr, rf_wdata); end
        issue(3'd2, 5'd8, 32'd0, 32'h0000_0ABC, 32'd0, 32'd0);
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h0000_0ABC)
            begin bad++; $display("FAIL b2b_imm got=%0b/%0d/%h want=1/8/00000abc", rf_we, rf_waddr, rf_wdata); end
        issue(3'd4, 5'd9, 32'd0, 32'h0000_0020, 32'hFFFF_FFF0, 32'd0);
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_0010)
            begin bad++; $display("FAIL b2b_pcimm got=%0b/%0d/%h want=1/9/00000010", rf_we, rf_waddr, rf_wdata); end
        issue(3'd1, 5'd10, 32'd0, 32'd0, 32'd0, 32'h1234_5678);
        in_ld_size = 2'b10;
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h1234_5678)
            begin bad++; $display("FAIL b2b_ldword got=%0b/%0d/%h want=1/10/12345678", rf_we, rf_waddr, rf_wdata); end
        idle();
        step();
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd10 || rf_wdata !== 32'h1234_5678)
            begin bad++; $display("FAIL b2b_hold got=%0b/%0d/%h want=0/10/12345678", rf_we, rf_waddr, rf_wdata); end
        total++; if (instret !== exp_cnt) begin bad++; $display("FAIL b2b_instret got=%0d want=%0d", instret, exp_cnt); end
        $display("test_back_to_back done");
    endtask

    task automatic test_nowrite();
        issue(3'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_we got=%0b want=0", rf_we); end
        total++; if (instret !== exp_cnt) begin bad++; $display("FAIL x0_instret got=%0d want=%0d", instret, exp_cnt); end
        issue(3'd6, 5'd3, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b0 || rf_wdata !== 32'd0 || rf_waddr !== 5'd3)
            begin bad++; $display("FAIL badsel got=%0b/%0d/%h want=0/3/00000000", rf_we, rf_waddr, rf_wdata); end
        issue(3'd0, 5'd4, 32'h0BAD_F00D, 32'd0, 32'd0, 32'd0);
        in_rd_we = 1'b0;
        step(); exp_cnt++;
        total++; if (rf_we !== 1'b0 || rf_wdata !== 32'h0BAD_F00D)
            begin bad++; $display("FAIL we0 got=%0b/%h want=0/0badf00d", rf_we, rf_wdata); end
        total++; if (instret !== exp_cnt) begin bad++; $display("FAIL nowrite_instret got=%0d want=%0d", instret, exp_cnt); end
        idle();
        $display("test_nowrite done");
    endtask

    task automatic test_load();
        logic [31:0] want [4];
`ifdef WB_LOAD_ALIGN_EN
        want[0] = 32'hFFFF_FF80; want[1] = 32'h0000_0080;
        want[2] = 32'h0000_1234; want[3] = 32'hFFFF_80FF;
`else
        want[0] = 32'h1234_80FF; want[1] = 32'h1234_80FF;
        want[2] = 32'h1234_80FF; want[3] = 32'h1234_80FF;
`endif
        for (int i = 0; i < 4; i++) begin
            issue(3'd1, 5'd11, 32'd0, 32'd0, 32'd0, 32'h1234_80FF);
            case (i)
                0: begin in_ld_size = 2'b00; in_addr_lo = 2'b01; in_ld_unsigned = 1'b0; end
                1: begin in_ld_size = 2'b00; in_addr_lo = 2'b01; in_ld_unsigned = 1'b1; end
                2: begin in_ld_size = 2'b01; in_addr_lo = 2'b10; in_ld_unsigned = 1'b0; end
                default: begin in_ld_size = 2'b01; in_addr_lo = 2'b00; in_ld_unsigned = 1'b0; end
            endcase
            step(); exp_cnt++;
            total++; if (rf_we !== 1'b1 || rf_wdata !== want[i])
                begin bad++; $display("FAIL load_%0d got=%0b/%h want=1/%h", i, rf_we, rf_wdata, want[i]); end
        end
        idle();
        $display("test_load done");
    endtask

    task automatic test_stall();
        issue(3'd0, 5'd12, 32'h0000_0055, 32'd0, 32'd0, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_%0d got=%0b want=0", i, in_ready); end
            step();
            total++; if (rf_we !== 1'b0 || instret !== exp_cnt)
                begin bad++; $display("FAIL stall_%0d got=%0b/%0d want=0/%0d", i, rf_we, instret, exp_cnt); end
        end
        stall = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL unstall_ready got=%0b want=1", in_ready); end
        step(); exp_cnt++;
        idle();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h0000_0055 || instret !== exp_cnt)
            begin bad++; $display("FAIL unstall got=%0b/%0d/%h/%0d want=1/12/00000055/%0d", rf_we, rf_waddr, rf_wdata, instret, exp_cnt); end
        $display("test_stall done");
    endtask

    task automatic test_flush();
        issue(3'd0, 5'd13, 32'h0000_0066, 32'd0, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        total++; if (rf_we !== 1'b0 || rf_wdata !== 32'h0000_0055 || instret !== exp_cnt)
            begin bad++; $display("FAIL flush got=%0b/%h/%0d want=0/00000055/%0d", rf_we, rf_wdata, instret, exp_cnt); end
        stall = 1'b1;
        step();
        total++; if (rf_we !== 1'b0 || instret !== exp_cnt)
            begin bad++; $display("FAIL stall_flush got=%0b/%0d want=0/%0d", rf_we, instret, exp_cnt); end
        stall = 1'b0; flush = 1'b0;
        idle();
        $display("test_flush done");
    endtask

    task automatic test_rst_mid();
        issue(3'd0, 5'd14, 32'h0000_0077, 32'd0, 32'd0, 32'd0);
        step(); exp_cnt++;
        idle();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL pre_rst_we got=%0b want=1", rf_we); end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || instret !== 64'd0)
            begin bad++; $display("FAIL async_rst got=%0b/%0d/%h/%0d want=0/0/0/0", rf_we, rf_waddr, rf_wdata, instret); end
        #1;
        rst = 1'b0; exp_cnt = 64'd0;
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL post_rst_we got=%0b want=0", rf_we); end
        issue(3'd3, 5'd15, 32'd0, 32'd0, 32'h0000_2000, 32'd0);
        step(); exp_cnt++;
        idle();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd15 || rf_wdata !== 32'h0000_2004 || instret !== 64'd1)
            begin bad++; $display("FAIL post_rst_accept got=%0b/%0d/%h/%0d want=1/15/00002004/1", rf_we, rf_waddr, rf_wdata, instret); end
        $display("test_rst_mid done");
    endtask

    task automatic test_wrap();
        rst = 1'b1; #1; rst = 1'b0;
        total++; if (s_instret !== 4'd0) begin bad++; $display("FAIL wrap_start got=%0d want=0", s_instret); end
        issue(3'd0, 5'd1, 32'h0000_0001, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 15; i++) step();
        total++; if (s_instret !== 4'd15 || instret !== 64'd15)
            begin bad++; $display("FAIL wrap_full got=%0d/%0d want=15/15", s_instret, instret); end
        step();
        idle();
        total++; if (s_instret !== 4'd0 || instret !== 64'd16)
            begin bad++; $display("FAIL wrap_zero got=%0d/%0d want=0/16", s_instret, instret); end
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_pc4();
        test_back_to_back();
        test_nowrite();
        test_load();
        test_stall();
        test_flush();
        test_rst_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
